// File: rtl/c64_mem_pkg.sv
// c64_mem_pkg
//   Shared definitions for the C64 memory map: region boundary addresses,
//   the decoded-region enumeration, the default processor-port fade time and
//   the region decode helper used by c64_mem_map.
package c64_mem_pkg;

  // Default number of clk cycles the floating port bits 7:6 keep their value.
  localparam logic [15:0] FADE_CYCLES_DEFAULT = 16'd1000;

  // Processor-port register addresses.
  localparam logic [15:0] PORT_DIR_ADDR  = 16'h0000;
  localparam logic [15:0] PORT_DATA_ADDR = 16'h0001;

  // Banked region boundaries (inclusive).
  localparam logic [15:0] BASIC_BASE  = 16'hA000;
  localparam logic [15:0] BASIC_END   = 16'hBFFF;
  localparam logic [15:0] IO_BASE     = 16'hD000;
  localparam logic [15:0] IO_END      = 16'hDFFF;
  localparam logic [15:0] KERNAL_BASE = 16'hE000;

  typedef enum logic [2:0] {
    REGION_RAM    = 3'd0,
    REGION_BASIC  = 3'd1,
    REGION_KERNAL = 3'd2,
    REGION_CHAR   = 3'd3,
    REGION_IO     = 3'd4,
    REGION_PORT   = 3'd5
  } region_e;

  // Map an address plus the three banking bits to the region that serves it.
  // The $D000 window shows RAM only when both LORAM and HIRAM are low;
  // otherwise CHAREN chooses between I/O and the character ROM.
  function automatic region_e decode_region(input logic [15:0] addr,
                                            input logic loram,
                                            input logic hiram,
                                            input logic charen);
    region_e r;
    r = REGION_RAM;
    if ((addr == PORT_DIR_ADDR) || (addr == PORT_DATA_ADDR)) begin
      r = REGION_PORT;
    end else if ((addr >= BASIC_BASE) && (addr <= BASIC_END)) begin
      if (loram && hiram) begin
        r = REGION_BASIC;
      end else begin
        r = REGION_RAM;
      end
    end else if ((addr >= IO_BASE) && (addr <= IO_END)) begin
      if (!loram && !hiram) begin
        r = REGION_RAM;
      end else if (charen) begin
        r = REGION_IO;
      end else begin
        r = REGION_CHAR;
      end
    end else if (addr >= KERNAL_BASE) begin
      if (hiram) begin
        r = REGION_KERNAL;
      end else begin
        r = REGION_RAM;
      end
    end else begin
      r = REGION_RAM;
    end
    return r;
  endfunction

endpackage

// File: rtl/c64_mem_map_cpu_port.sv
// cpu_port
//   6510 on-chip I/O port: direction register ($0000), data register ($0001)
//   and the capacitive "fade" behaviour of the unconnected bits 7:6.
//   When bit 7 or 6 is switched from output to input, its last driven value
//   is held for FADE_CYCLES cycles, then reads 0.
// Ports
//   clk, reset     : system clock, asynchronous active-high reset
//   wr_dir_i       : load the direction register from wdata_i this edge
//   wr_out_i       : load the data register from wdata_i this edge
//   wdata_i        : CPU write data
//   port_in_i      : external pin levels (bits 5:0 meaningful)
//   port_dir_o     : direction register (1 = output)
//   port_out_o     : data register
//   port_rd_o      : value the CPU sees when reading $0001
module cpu_port
  import c64_mem_pkg::*;
#(
  parameter logic [15:0] FADE_CYCLES = FADE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_dir_i,
  input  logic       wr_out_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] port_in_i,
  output logic [7:0] port_dir_o,
  output logic [7:0] port_out_o,
  output logic [7:0] port_rd_o
);

  logic [7:0] dir_q, dir_d;
  logic [7:0] out_q, out_d;
  logic [1:0] fade_bits_s;
  logic       unused_pins;

  // Pins 7:6 are not bonded out; the fade latch stands in for them.
  assign unused_pins = ^port_in_i[7:6];

  // Next value of the direction and data registers.
  always_comb begin
    dir_d = dir_q;
    out_d = out_q;
    if (wr_dir_i) begin
      dir_d = wdata_i;
    end else begin
      dir_d = dir_q;
    end
    if (wr_out_i) begin
      out_d = wdata_i;
    end else begin
      out_d = out_q;
    end
  end

  // Direction and data register storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q <= 8'h00;
      out_q <= 8'h00;
    end else begin
      dir_q <= dir_d;
      out_q <= out_d;
    end
  end

  // One fade latch and down-counter per floating bit (6 and 7).
  for (genvar g = 0; g < 2; g++) begin : g_fade
    localparam int unsigned B = 6 + g;

    logic        fade_q, fade_d;
    logic [15:0] cnt_q, cnt_d;

    // Fade sequencing. A falling direction bit captures the value that was
    // driven before this edge, so a simultaneous data write does not leak in.
    always_comb begin
      fade_d = fade_q;
      cnt_d  = cnt_q;
      if (dir_q[B] && !dir_d[B]) begin
        if (FADE_CYCLES != 16'd0) begin
          fade_d = out_q[B];
          cnt_d  = FADE_CYCLES;
        end else begin
          fade_d = 1'b0;
          cnt_d  = 16'd0;
        end
      end else if (dir_d[B]) begin
        fade_d = out_d[B];
        cnt_d  = 16'd0;
      end else if (cnt_q != 16'd0) begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          fade_d = 1'b0;
        end else begin
          fade_d = fade_q;
        end
      end else begin
        fade_d = fade_q;
        cnt_d  = cnt_q;
      end
    end

    // Fade latch and counter storage; reset abandons any fade in flight.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        fade_q <= 1'b0;
        cnt_q  <= 16'd0;
      end else begin
        fade_q <= fade_d;
        cnt_q  <= cnt_d;
      end
    end

    assign fade_bits_s[g] = fade_q;
  end

  // Port read value: output bits echo the data register, inputs show the pins
  // (or the fade latch for the floating bits).
  always_comb begin
    port_rd_o = 8'h00;
    for (int i = 0; i < 6; i++) begin
      if (dir_q[i]) begin
        port_rd_o[i] = out_q[i];
      end else begin
        port_rd_o[i] = port_in_i[i];
      end
    end
    for (int j = 0; j < 2; j++) begin
      if (dir_q[6 + j]) begin
        port_rd_o[6 + j] = out_q[6 + j];
      end else begin
        port_rd_o[6 + j] = fade_bits_s[j];
      end
    end
  end

  assign port_dir_o = dir_q;
  assign port_out_o = out_q;

endmodule

// File: rtl/c64_mem_map.sv
// c64_mem_map
//   C64 address decoder and read-data multiplexer around the 6510 processor
//   port. Reads are purely combinational (zero latency).
// Ports
//   clk, reset        : system clock, asynchronous active-high reset
//   ab, we            : CPU address and write enable
//   dout              : CPU write data ("do" is a reserved word)
//   di                : read data to the CPU
//   port_in/out/dir   : processor port pins, data and direction registers
//   ram_addr/we/wdata : 64 KiB RAM, ram_rdata is its asynchronous read data
//   basic/kernal/char_rdata : ROM data (ROMs are addressed externally from ab)
//   io_cs, io_we, io_rdata  : $D000-$DFFF I/O space when I/O is banked in
module c64_mem_map
  import c64_mem_pkg::*;
#(
  parameter logic [15:0] FADE_CYCLES = FADE_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ab,
  input  logic        we,
  input  logic [7:0]  dout,
  output logic [7:0]  di,
  input  logic [7:0]  port_in,
  output logic [7:0]  port_out,
  output logic [7:0]  port_dir,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  input  logic [7:0]  basic_rdata,
  input  logic [7:0]  kernal_rdata,
  input  logic [7:0]  char_rdata,
  output logic        io_cs,
  output logic        io_we,
  input  logic [7:0]  io_rdata
);

  logic       wr_dir_s;
  logic       wr_out_s;
  logic [7:0] port_rd_s;
  logic [2:0] eff_s;
  region_e    region_s;

  assign wr_dir_s = we && (ab == PORT_DIR_ADDR);
  assign wr_out_s = we && (ab == PORT_DATA_ADDR);

  cpu_port #(
    .FADE_CYCLES(FADE_CYCLES)
  ) u_cpu_port (
    .clk        (clk),
    .reset      (reset),
    .wr_dir_i   (wr_dir_s),
    .wr_out_i   (wr_out_s),
    .wdata_i    (dout),
    .port_in_i  (port_in),
    .port_dir_o (port_dir),
    .port_out_o (port_out),
    .port_rd_o  (port_rd_s)
  );

  // Effective banking bits: driven value for outputs, pin level for inputs.
  always_comb begin
    eff_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (port_dir[i]) begin
        eff_s[i] = port_out[i];
      end else begin
        eff_s[i] = port_in[i];
      end
    end
  end

  assign region_s = decode_region(ab, eff_s[0], eff_s[1], eff_s[2]);

  // Read data multiplexer.
  always_comb begin
    di = ram_rdata;
    case (region_s)
      REGION_PORT: begin
        if (ab[0]) begin
          di = port_rd_s;
        end else begin
          di = port_dir;
        end
      end
      REGION_BASIC:  di = basic_rdata;
      REGION_KERNAL: di = kernal_rdata;
      REGION_CHAR:   di = char_rdata;
      REGION_IO:     di = io_rdata;
      REGION_RAM:    di = ram_rdata;
      default:       di = ram_rdata;
    endcase
  end

  // Writes land in RAM everywhere except banked-in I/O, including under ROMs
  // and at the port registers. Strobes are held off while reset is high.
  assign io_cs     = (region_s == REGION_IO);
  assign io_we     = io_cs && we && !reset;
  assign ram_we    = !io_cs && we && !reset;
  assign ram_addr  = ab;
  assign ram_wdata = dout;

endmodule

// File: tb/tb_c64_mem_map.sv
module tb_c64_mem_map;
  localparam logic [15:0] TB_FADE = 16'd25;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ab;
  logic        we;
  logic [7:0]  dout, di, port_in, port_out, port_dir;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata, ram_rdata, basic_rdata, kernal_rdata, char_rdata;
  logic        io_cs, io_we;
  logic [7:0]  io_rdata;

  c64_mem_map #(.FADE_CYCLES(TB_FADE)) dut (
    .clk(clk), .reset(reset), .ab(ab), .we(we), .dout(dout), .di(di),
    .port_in(port_in), .port_out(port_out), .port_dir(port_dir),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .basic_rdata(basic_rdata),
    .kernal_rdata(kernal_rdata), .char_rdata(char_rdata),
    .io_cs(io_cs), .io_we(io_we), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: registers plus, for bits 7:6, the cycle a fade began.
  logic [7:0] m_dir, m_out;
  int         cyc;
  bit         fa [2];
  bit         fv [2];
  int         fcyc [2];

  // Values observed during the last step, for directed checks.
  logic [7:0] obs_di;
  logic       obs_io_cs, obs_io_we, obs_ram_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_port_rd();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) begin
      if (m_dir[i]) v[i] = m_out[i];
      else if (i < 6) v[i] = port_in[i];
      else v[i] = (fa[i-6] && ((cyc - fcyc[i-6]) < int'(TB_FADE))) ? fv[i-6] : 1'b0;
    end
    return v;
  endfunction

  function automatic bit m_bit(input int b);
    return m_dir[b] ? m_out[b] : port_in[b];
  endfunction

  function automatic bit m_io_mapped();
    return (ab >= 16'hD000) && (ab <= 16'hDFFF) && (m_bit(0) || m_bit(1)) && m_bit(2);
  endfunction

  function automatic logic [7:0] m_di();
    bit lo, hi, ch;
    lo = m_bit(0); hi = m_bit(1); ch = m_bit(2);
    if (ab == 16'h0000) return m_dir;
    if (ab == 16'h0001) return m_port_rd();
    if (ab >= 16'hA000 && ab <= 16'hBFFF) return (lo && hi) ? basic_rdata : ram_rdata;
    if (ab >= 16'hD000 && ab <= 16'hDFFF) begin
      if (!lo && !hi) return ram_rdata;
      return ch ? io_rdata : char_rdata;
    end
    if (ab >= 16'hE000) return hi ? kernal_rdata : ram_rdata;
    return ram_rdata;
  endfunction

  task automatic model_reset();
    m_dir = 8'h00; m_out = 8'h00;
    fa[0] = 1'b0; fa[1] = 1'b0;
  endtask

  // One bus cycle: drive, check combinational outputs, clock, update model.
  task automatic step(input logic [15:0] a, input logic w, input logic [7:0] d);
    logic [7:0] nd, no;
    ab = a; we = w; dout = d;
    #1;
    obs_di = di; obs_io_cs = io_cs; obs_io_we = io_we; obs_ram_we = ram_we;
    chk("di", di, m_di());
    chk("io_cs", io_cs, m_io_mapped());
    chk("io_we", io_we, m_io_mapped() && w);
    chk("ram_we", ram_we, !m_io_mapped() && w);
    chk("ram_addr", ram_addr, a);
    chk("ram_wdata", ram_wdata, d);
    chk("port_dir", port_dir, m_dir);
    chk("port_out", port_out, m_out);
    @(posedge clk);
    nd = (w && a == 16'h0000) ? d : m_dir;
    no = (w && a == 16'h0001) ? d : m_out;
    cyc++;
    for (int b = 0; b < 2; b++) begin
      if (m_dir[6+b] && !nd[6+b]) begin
        fa[b] = 1'b1; fv[b] = m_out[6+b]; fcyc[b] = cyc;
      end else if (nd[6+b]) begin
        fa[b] = 1'b0;
      end
    end
    m_dir = nd; m_out = no;
    #1;
  endtask

  initial begin
    reset = 1'b1; ab = 16'h0000; we = 1'b0; dout = 8'h00; port_in = 8'hFF;
    ram_rdata = 8'h11; basic_rdata = 8'h94; kernal_rdata = 8'h85;
    char_rdata = 8'h5A; io_rdata = 8'hC3;
    cyc = 0; fcyc[0] = 0; fcyc[1] = 0;
    model_reset();
    #2;
    we = 1'b1;
    #1;
    chk("rst_dir", port_dir, 8'h00);
    chk("rst_out", port_out, 8'h00);
    chk("rst_ram_we", ram_we, 1'b0);
    we = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Default banking with all pins high.
    step(16'h0000, 1'b0, 8'h00); chk("rd_0000", obs_di, 8'h00);
    step(16'hE000, 1'b0, 8'h00); chk("kernal", obs_di, 8'h85);
    step(16'hA000, 1'b0, 8'h00); chk("basic", obs_di, 8'h94);
    step(16'hD000, 1'b0, 8'h00); chk("io_cs_d000", obs_io_cs, 1'b1);

    // HIRAM low: ROMs drop out, I/O stays.
    step(16'h0000, 1'b1, 8'h07);
    step(16'h0001, 1'b1, 8'h05);
    ram_rdata = 8'h3C;
    step(16'hE000, 1'b0, 8'h00); chk("e000_ram", obs_di, 8'h3C);
    step(16'hA000, 1'b0, 8'h00); chk("a000_ram", obs_di, 8'h3C);
    step(16'hD000, 1'b0, 8'h00); chk("d000_io", obs_io_cs, 1'b1);

    // CHAREN low: character ROM, writes go to RAM.
    step(16'h0001, 1'b1, 8'h03);
    step(16'hD000, 1'b0, 8'h00); chk("char", obs_di, 8'h5A);
    step(16'hD000, 1'b1, 8'hEE);
    chk("d000_ram_we", obs_ram_we, 1'b1);
    chk("d000_io_we", obs_io_we, 1'b0);

    // Port write also hits RAM, register visible next cycle.
    step(16'h0001, 1'b1, 8'hAA); chk("wr_0001_ram_we", obs_ram_we, 1'b1);
    step(16'h0001, 1'b0, 8'h00); chk("port_out_new", obs_di & 8'h07, 8'h02);

    // Fade of bits 7:6.
    step(16'h0000, 1'b1, 8'hC0);
    step(16'h0001, 1'b1, 8'hC0);
    step(16'h0000, 1'b1, 8'h00);
    for (int k = 0; k < int'(TB_FADE); k++) begin
      step(16'h0001, 1'b0, 8'h00);
      chk("fade_hold", obs_di[7:6], 2'b11);
    end
    step(16'h0001, 1'b0, 8'h00); chk("fade_end", obs_di[7:6], 2'b00);

    // Cancel bit 7 mid-fade; bit 6 keeps fading.
    step(16'h0000, 1'b1, 8'hC0);
    step(16'h0000, 1'b1, 8'h00);
    for (int k = 0; k < 5; k++) step(16'h0001, 1'b0, 8'h00);
    step(16'h0000, 1'b1, 8'h80);
    step(16'h0001, 1'b0, 8'h00); chk("cancel_b7", obs_di[7:6], 2'b11);
    step(16'h0001, 1'b1, 8'h40);
    step(16'h0001, 1'b0, 8'h00); chk("b7_follows_out", obs_di[7], 1'b0);
    for (int k = 0; k < int'(TB_FADE); k++) step(16'h0001, 1'b0, 8'h00);
    chk("b6_faded", obs_di[6], 1'b0);

    // Reset mid-fade.
    step(16'h0000, 1'b1, 8'hC0);
    step(16'h0001, 1'b1, 8'hC0);
    step(16'h0000, 1'b1, 8'h00);
    step(16'h0001, 1'b0, 8'h00);
    port_in = 8'hFF; ab = 16'hD000; we = 1'b1;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_dir", port_dir, 8'h00);
    chk("mid_rst_out", port_out, 8'h00);
    chk("mid_rst_io_we", io_we, 1'b0);
    chk("mid_rst_ram_we", ram_we, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    step(16'h0001, 1'b0, 8'h00); chk("post_rst_fade", obs_di[7:6], 2'b00);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [15:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1: a = 16'h0000;
        2, 3: a = 16'h0001;
        4: a = 16'(16'hA000 + $urandom_range(0, 16'h1FFF));
        5: a = 16'(16'hD000 + $urandom_range(0, 16'h0FFF));
        6: a = 16'(16'hE000 + $urandom_range(0, 16'h1FFF));
        default: a = 16'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) port_in = 8'($urandom);
      ram_rdata = 8'($urandom); basic_rdata = 8'($urandom);
      kernal_rdata = 8'($urandom); char_rdata = 8'($urandom);
      io_rdata = 8'($urandom);
      step(a, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
